// File: rtl/mem_access_initiator.sv
// Data-memory initiator: one MEM-stage load/store -> aligned req/gnt/rvalid transaction, extended load data back.
// Latency: address error 1 cycle accept->done; store >=2; load >=3; abort after TIMEOUT REQ+RESP cycles.
// Backpressure: stall (combinational) holds the pipeline from accept until the cycle before done.
//
// Ports: clk/reset (async active-low); op_* = MEM-stage request; stall/done/rdata/adel/ades/bus_err =
// pipeline results; m_req/m_we/m_addr/m_be/m_wdata out and m_gnt/m_rvalid/m_rdata in = memory side.
module mem_access_initiator #(
    parameter logic [31:0] MEM_BASE = 32'h0000_0000,
    parameter logic [31:0] MEM_SIZE = 32'h0000_3000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [1:0]  op_type,
    input  logic [1:0]  op_size,
    input  logic        op_signed,
    input  logic [31:0] op_addr,
    input  logic [31:0] op_wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        adel,
    output logic        ades,
    output logic        bus_err,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [3:0]  m_be,
    output logic [31:0] m_wdata,
    input  logic        m_gnt,
    input  logic        m_rvalid,
    input  logic [31:0] m_rdata
);

    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [1:0]    size_q;
    logic          signed_q;
    logic [1:0]    off_q;

    logic          is_load, is_store, accept, addr_ok, align_ok, in_win;
    logic          launch, addr_err, fin_ok, fin_to, ld_cap, last;
    logic [3:0]    be_nxt;
    logic [31:0]   wd_nxt, ld_ext;
    logic [15:0]   ld_half;
    logic [7:0]    ld_byte;

    assign is_load  = (op_type == 2'b01);
    assign is_store = (op_type == 2'b10);
    // done blocks re-accept so the retiring op is not picked up a second time.
    assign accept   = (state == IDLE) && op_valid && (is_load || is_store) &&
                      (op_size != 2'b11) && !done;
    assign stall    = accept || (state != IDLE);
    assign m_req    = (state == REQ);
    assign last     = (cnt == CW'(TIMEOUT - 1));

    // 33-bit compare so a window ending at 4 GiB does not wrap.
    assign in_win   = ({1'b0, op_addr} >= {1'b0, MEM_BASE}) &&
                      ({1'b0, op_addr} <  ({1'b0, MEM_BASE} + {1'b0, MEM_SIZE}));

    always_comb begin
        align_ok = 1'b1;
        be_nxt   = 4'b0000;
        wd_nxt   = 32'h0;
        case (op_size)
            2'b00: begin
                align_ok = (op_addr[1:0] == 2'b00);
                be_nxt   = 4'b1111;
                wd_nxt   = op_wdata;
            end
            2'b01: begin
                align_ok = !op_addr[0];
                be_nxt   = op_addr[1] ? 4'b1100 : 4'b0011;
                wd_nxt   = {2{op_wdata[15:0]}};
            end
            2'b10: begin
                be_nxt   = 4'b0001 << op_addr[1:0];
                wd_nxt   = {4{op_wdata[7:0]}};
            end
            default: ;
        endcase
    end

    assign addr_ok  = align_ok && in_win;
    assign launch   = accept && addr_ok;
    assign addr_err = accept && !addr_ok;

    always_comb begin
        ld_half = off_q[1] ? m_rdata[31:16] : m_rdata[15:0];
        ld_byte = m_rdata[{off_q, 3'b000} +: 8];
        case (size_q)
            2'b01:   ld_ext = {{16{signed_q & ld_half[15]}}, ld_half};
            2'b10:   ld_ext = {{24{signed_q & ld_byte[7]}}, ld_byte};
            default: ld_ext = m_rdata;
        endcase
    end

    always_comb begin
        state_nxt = state;
        fin_ok    = 1'b0;
        fin_to    = 1'b0;
        ld_cap    = 1'b0;
        case (state)
            IDLE: begin
                if (launch) state_nxt = REQ;
            end
            REQ: begin
                // A load grant on the final budget cycle cannot finish in time, so it aborts.
                if (m_gnt && m_we) begin
                    state_nxt = IDLE;
                    fin_ok    = 1'b1;
                end else if (last) begin
                    state_nxt = IDLE;
                    fin_to    = 1'b1;
                end else if (m_gnt) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (m_rvalid) begin
                    state_nxt = IDLE;
                    fin_ok    = 1'b1;
                    ld_cap    = 1'b1;
                end else if (last) begin
                    state_nxt = IDLE;
                    fin_to    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            done     <= 1'b0;
            adel     <= 1'b0;
            ades     <= 1'b0;
            bus_err  <= 1'b0;
            rdata    <= 32'h0;
            m_we     <= 1'b0;
            m_addr   <= 32'h0;
            m_be     <= 4'h0;
            m_wdata  <= 32'h0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            off_q    <= 2'b00;
        end else begin
            state   <= state_nxt;
            done    <= fin_ok | fin_to | addr_err;
            adel    <= addr_err & is_load;
            ades    <= addr_err & is_store;
            bus_err <= fin_to;
            if (ld_cap) rdata <= ld_ext;
            if (launch) begin
                m_addr   <= {op_addr[31:2], 2'b00};
                m_we     <= is_store;
                m_be     <= be_nxt;
                m_wdata  <= wd_nxt;
                size_q   <= op_size;
                signed_q <= op_signed;
                off_q    <= op_addr[1:0];
                cnt      <= '0;
            end else if (state != IDLE) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_initiator.sv
// Bench for mem_access_initiator: directed table, reset-abort sequence, random ops vs reference model.
// Latency: not applicable.
// Backpressure: bench acts as the memory responder with programmable grant/rvalid delays.
module tb_mem_access_initiator;

    localparam logic [31:0] MEM_BASE = 32'h0000_0000;
    localparam logic [31:0] MEM_SIZE = 32'h0000_3000;
    localparam int          TIMEOUT  = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid, op_signed;
    logic [1:0]  op_type, op_size;
    logic [31:0] op_addr, op_wdata;
    logic        stall, done, adel, ades, bus_err;
    logic [31:0] rdata;
    logic        m_req, m_we, m_gnt, m_rvalid;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_be;

    always #5 clk = ~clk;

    mem_access_initiator #(
        .MEM_BASE(MEM_BASE), .MEM_SIZE(MEM_SIZE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .op_valid(op_valid), .op_type(op_type), .op_size(op_size), .op_signed(op_signed),
        .op_addr(op_addr), .op_wdata(op_wdata),
        .stall(stall), .done(done), .rdata(rdata), .adel(adel), .ades(ades), .bus_err(bus_err),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_be(m_be), .m_wdata(m_wdata),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
    );

    typedef struct {
        logic [1:0]  typ, sz;
        logic        sgn;
        logic [31:0] addr, wd, word;
        int          gd, rd;          // grant delay (REQ cycles), rvalid delay (RESP cycles)
    } vec_t;

    typedef struct {
        int          lat, nreq;       // lat 0 means no done expected
        logic [3:0]  be;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata, rdata;
        logic [2:0]  flags;           // {adel, ades, bus_err}
    } exp_t;

    typedef struct {
        int          lat, nreq, nstall;
        logic        stall0, post_ok, stable;
        logic [3:0]  be;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata, rdata;
        logic [2:0]  flags;
    } obs_t;

    typedef struct {
        vec_t v;
        exp_t e;
    } tv_t;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_total++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, want);
    endtask

    // Reference model: derived from access width, lane arithmetic and cycle budget.
    function automatic exp_t model(input vec_t v, input logic [31:0] held);
        exp_t        e;
        int          nb, lane, need;
        logic [31:0] val, mask;
        longint      a;
        e.lat = 0; e.nreq = 0; e.be = 4'h0; e.addr = v.addr & 32'hFFFF_FFFC;
        e.we = (v.typ == 2'b10); e.wdata = 32'h0; e.rdata = held; e.flags = 3'b000;
        if (!((v.typ == 2'b01 || v.typ == 2'b10) && v.sz != 2'b11)) return e;
        nb   = (v.sz == 2'b00) ? 4 : (v.sz == 2'b01) ? 2 : 1;
        lane = int'(v.addr % 4);
        a    = longint'(v.addr);
        if ((v.addr % 32'(nb)) != 0 || a < longint'(MEM_BASE) ||
            a >= longint'(MEM_BASE) + longint'(MEM_SIZE)) begin
            e.lat   = 1;
            e.flags = e.we ? 3'b010 : 3'b100;
            return e;
        end
        for (int i = 0; i < nb; i++) e.be[lane + i] = 1'b1;
        case (nb)
            4:       e.wdata = v.wd;
            2:       e.wdata = (v.wd & 32'h0000_FFFF) * 32'h0001_0001;
            default: e.wdata = (v.wd & 32'h0000_00FF) * 32'h0101_0101;
        endcase
        need = e.we ? v.gd + 1 : v.gd + v.rd + 2;
        if (need > TIMEOUT) begin
            e.lat   = TIMEOUT + 1;
            e.nreq  = (v.gd + 1 < TIMEOUT) ? v.gd + 1 : TIMEOUT;
            e.flags = 3'b001;
        end else begin
            e.lat  = need + 1;
            e.nreq = v.gd + 1;
            if (!e.we) begin
                mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
                val  = (v.word >> (8 * lane)) & mask;
                if (v.sgn && nb < 4 && val[8 * nb - 1]) val = val | ~mask;
                e.rdata = val;
            end
        end
        return e;
    endfunction

    function automatic tv_t mk(input logic [1:0] typ, input logic [1:0] sz, input logic sgn,
                               input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] word,
                               input int gd, input int rd, input int lat, input int nreq,
                               input logic [3:0] be, input logic [31:0] wdata,
                               input logic [31:0] rd_exp, input logic [2:0] flags);
        tv_t t;
        t.v = '{typ, sz, sgn, addr, wd, word, gd, rd};
        t.e.lat = lat; t.e.nreq = nreq; t.e.be = be; t.e.addr = addr & 32'hFFFF_FFFC;
        t.e.we = (typ == 2'b10); t.e.wdata = wdata; t.e.rdata = rd_exp; t.e.flags = flags;
        return t;
    endfunction

    // Presents one op, plays responder, and records what the DUT did. Bounded to 40 cycles.
    task automatic run_op(input vec_t v, output obs_t o);
        int gc, rc;
        bit in_resp, first;
        o = '{default: 0};
        o.stable = 1'b1;
        @(negedge clk);
        op_valid = 1'b1; op_type = v.typ; op_size = v.sz; op_signed = v.sgn;
        op_addr = v.addr; op_wdata = v.wd;
        #1 o.stall0 = stall;
        gc = 0; rc = 0; in_resp = 0; first = 1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (stall) o.nstall++;
            if (done) begin
                o.lat   = k;
                o.flags = {adel, ades, bus_err};
                break;
            end
            if (m_req) begin
                if (first) begin
                    o.be = m_be; o.addr = m_addr; o.we = m_we; o.wdata = m_wdata; first = 0;
                end else if (m_be !== o.be || m_addr !== o.addr || m_we !== o.we || m_wdata !== o.wdata) begin
                    o.stable = 1'b0;
                end
                o.nreq++;
            end
            if (in_resp) begin
                m_gnt = 1'($urandom_range(0, 1));
                if (rc == v.rd) begin
                    m_rvalid = 1'b1; m_rdata = v.word; in_resp = 0;
                end else begin
                    m_rvalid = 1'b0; m_rdata = $urandom;
                end
                rc++;
            end else if (m_req) begin
                m_gnt    = (gc == v.gd);
                m_rvalid = 1'($urandom_range(0, 1));   // stray rvalid during REQ must be ignored
                m_rdata  = $urandom;
                gc++;
                if (m_gnt && v.typ == 2'b01) begin in_resp = 1; rc = 0; end
            end else begin
                m_gnt = 1'b0; m_rvalid = 1'b0;
            end
        end
        op_valid = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b0;
        o.rdata = rdata;
        @(negedge clk);
        o.post_ok = !m_req && !done && !stall;
    endtask

    task automatic check_op(input string t, input exp_t e, input obs_t o);
        chk({t, ".lat"},    32'(o.lat), 32'(e.lat));
        chk({t, ".stall0"}, 32'(o.stall0), 32'(e.lat > 0));
        chk({t, ".nstall"}, 32'(o.nstall), 32'((e.lat > 0) ? e.lat - 1 : 0));
        chk({t, ".flags"},  32'(o.flags), 32'(e.flags));
        chk({t, ".rdata"},  o.rdata, e.rdata);
        chk({t, ".nreq"},   32'(o.nreq), 32'(e.nreq));
        chk({t, ".post"},   32'(o.post_ok), 32'd1);
        if (e.nreq > 0) begin
            chk({t, ".be"},     32'(o.be), 32'(e.be));
            chk({t, ".addr"},   o.addr, e.addr);
            chk({t, ".we"},     32'(o.we), 32'(e.we));
            chk({t, ".wdata"},  o.wdata, e.wdata);
            chk({t, ".stable"}, 32'(o.stable), 32'd1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tv_t         tbl[16];
        vec_t        v;
        exp_t        e;
        obs_t        o;
        logic [31:0] held;
        int          nd, r;

        reset = 1'b0; op_valid = 1'b0; op_type = 2'b00; op_size = 2'b00; op_signed = 1'b0;
        op_addr = 32'h0; op_wdata = 32'h0; m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0;

        //            typ    sz     s     addr          wd            word          gd  rd  lat nreq be       wdata         rdata         flags
        tbl[0]  = mk(2'b10, 2'b00, 1'b0, 32'h0000_0010, 32'h1234_5678, 32'h0,        0,  0,  2,  1, 4'b1111, 32'h1234_5678, 32'h0000_0000, 3'b000);
        tbl[1]  = mk(2'b01, 2'b10, 1'b1, 32'h0000_0013, 32'h0,         32'h80FF_0000, 0,  3,  6,  1, 4'b1000, 32'h0,         32'hFFFF_FF80, 3'b000);
        tbl[2]  = mk(2'b01, 2'b01, 1'b0, 32'h0000_0012, 32'h0,         32'hBEEF_1234, 0,  0,  3,  1, 4'b1100, 32'h0,         32'h0000_BEEF, 3'b000);
        tbl[3]  = mk(2'b10, 2'b01, 1'b0, 32'h0000_0012, 32'h0000_ABCD, 32'h0,        1,  0,  3,  2, 4'b1100, 32'hABCD_ABCD, 32'h0000_BEEF, 3'b000);
        tbl[4]  = mk(2'b01, 2'b00, 1'b0, 32'h0000_0006, 32'h0,         32'h0,        0,  0,  1,  0, 4'b0000, 32'h0,         32'h0000_BEEF, 3'b100);
        tbl[5]  = mk(2'b10, 2'b00, 1'b0, 32'h0000_3000, 32'h1,         32'h0,        0,  0,  1,  0, 4'b0000, 32'h0,         32'h0000_BEEF, 3'b010);
        tbl[6]  = mk(2'b01, 2'b00, 1'b0, 32'h0000_0020, 32'h0,         32'h0,       99,  0, 17, 16, 4'b1111, 32'h0,         32'h0000_BEEF, 3'b001);
        tbl[7]  = mk(2'b01, 2'b00, 1'b0, 32'h0000_2FFC, 32'h0,         32'hCAFE_F00D, 2,  1,  6,  3, 4'b1111, 32'h0,         32'hCAFE_F00D, 3'b000);
        tbl[8]  = mk(2'b01, 2'b10, 1'b0, 32'h0000_0011, 32'h0,         32'h1234_80AB, 0,  0,  3,  1, 4'b0010, 32'h0,         32'h0000_0080, 3'b000);
        tbl[9]  = mk(2'b10, 2'b01, 1'b0, 32'h0000_0013, 32'h5555,      32'h0,        0,  0,  1,  0, 4'b0000, 32'h0,         32'h0000_0080, 3'b010);
        tbl[10] = mk(2'b01, 2'b01, 1'b1, 32'h0000_0002, 32'h0,         32'h8001_7FFF, 0, 20, 17,  1, 4'b1100, 32'h0,         32'h0000_0080, 3'b001);
        tbl[11] = mk(2'b10, 2'b00, 1'b0, 32'h0000_2FFC, 32'hDEAD_BEEF, 32'h0,       15,  0, 17, 16, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0080, 3'b000);
        tbl[12] = mk(2'b00, 2'b00, 1'b0, 32'h0000_0040, 32'h0,         32'h0,        0,  0,  0,  0, 4'b0000, 32'h0,         32'h0000_0080, 3'b000);
        tbl[13] = mk(2'b01, 2'b11, 1'b0, 32'h0000_0040, 32'h0,         32'h0,        0,  0,  0,  0, 4'b0000, 32'h0,         32'h0000_0080, 3'b000);
        tbl[14] = mk(2'b10, 2'b10, 1'b0, 32'h0000_2FFF, 32'h0000_01A5, 32'h0,        0,  0,  2,  1, 4'b1000, 32'hA5A5_A5A5, 32'h0000_0080, 3'b000);
        tbl[15] = mk(2'b01, 2'b01, 1'b1, 32'h0000_0000, 32'h0,         32'h0000_8001, 0,  0,  3,  1, 4'b0011, 32'h0,         32'hFFFF_8001, 3'b000);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst.stall", 32'(stall), 32'd0);
        chk("rst.done",  32'(done), 32'd0);
        chk("rst.m_req", 32'(m_req), 32'd0);
        chk("rst.m_we",  32'(m_we), 32'd0);
        chk("rst.flags", 32'({adel, ades, bus_err}), 32'd0);
        chk("rst.m_addr", m_addr, 32'h0);
        chk("rst.m_be",  32'(m_be), 32'd0);
        chk("rst.m_wdata", m_wdata, 32'h0);
        chk("rst.rdata", rdata, 32'h0);
        reset = 1'b1;

        for (int i = 0; i < 16; i++) begin
            run_op(tbl[i].v, o);
            check_op($sformatf("tbl%0d", i), tbl[i].e, o);
        end

        // Reset while waiting for load data; late rvalid must not produce a done.
        @(negedge clk);
        op_valid = 1'b1; op_type = 2'b01; op_size = 2'b00; op_signed = 1'b0;
        op_addr = 32'h0000_0040; op_wdata = 32'h0;
        @(negedge clk);
        chk("rs.req", 32'(m_req), 32'd1);
        m_gnt = 1'b1;
        @(negedge clk);
        m_gnt = 1'b0;
        chk("rs.resp_req", 32'(m_req), 32'd0);
        reset = 1'b0;
        op_valid = 1'b0;
        #1;
        chk("rs.m_req", 32'(m_req), 32'd0);
        chk("rs.stall", 32'(stall), 32'd0);
        chk("rs.rdata", rdata, 32'h0);
        chk("rs.m_be",  32'(m_be), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        m_rvalid = 1'b1; m_rdata = 32'h1111_2222;
        @(negedge clk);
        m_rvalid = 1'b0;
        nd = 0;
        repeat (3) begin
            if (done || stall || m_req) nd++;
            @(negedge clk);
        end
        chk("rs.quiet", 32'(nd), 32'd0);
        chk("rs.rdata_after", rdata, 32'h0);
        held = 32'h0;
        v = '{2'b01, 2'b00, 1'b0, 32'h0000_0044, 32'h0, 32'h5A5A_0001, 0, 0};
        e = model(v, held);
        run_op(v, o);
        check_op("rs.next", e, o);
        held = e.rdata;

        // Randomised ops against the reference model
        for (int n = 0; n < 60; n++) begin
            v.typ  = ($urandom_range(0, 7) < 6) ? (($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10)
                                                : 2'($urandom_range(0, 3));
            v.sz   = 2'($urandom_range(0, 3));
            v.sgn  = 1'($urandom_range(0, 1));
            r      = int'($urandom_range(0, 3));
            if (r == 0)      v.addr = 32'h0000_2FF0 + $urandom_range(0, 31);
            else if (r == 3) v.addr = $urandom;
            else             v.addr = $urandom_range(0, 32'h2FFF) &
                                      ((v.sz == 2'b00) ? 32'hFFFF_FFFC : (v.sz == 2'b01) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF);
            v.wd   = $urandom;
            v.word = $urandom;
            v.gd   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(12, 20)) : int'($urandom_range(0, 3));
            v.rd   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(12, 20)) : int'($urandom_range(0, 3));
            e = model(v, held);
            run_op(v, o);
            check_op($sformatf("rnd%0d", n), e, o);
            held = e.rdata;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
